// File: rtl/cv32e40p_instr_obi_arbiter.sv
// Two-requester arbiter for the single instruction OBI port.
// Round-robin address-phase arbitration with address-phase hold until granted,
// and an in-order owner FIFO that routes each response back to its requester.
// Optional feature macro: CV32E40P_INSTR_ARB_LOCK_EN (requester 1 bus lock).
module cv32e40p_instr_obi_arbiter #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,
    input  logic        m1_lock_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o,
    output logic        protocol_err_o
);

    typedef enum logic [1:0] {
        StArb   = 2'd0,
        StHold0 = 2'd1,
        StHold1 = 2'd2
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [3:0]  r_owner;       // owner ID per FIFO slot, only DEPTH slots used
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [2:0]  r_count;
    logic        r_rr_prio;     // requester that wins the next tie
    logic        r_protocol_err;

    logic        w_full;
    logic        w_lock_active;
    logic        w_arb_any;
    logic        w_arb_sel;
    logic        w_req;
    logic        w_sel;
    logic        w_push;
    logic        w_pop;
    logic        w_head;

`ifdef CV32E40P_INSTR_ARB_LOCK_EN
    logic r_locked;

    // Lock engages on a locked grant to requester 1, drops once lock is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_locked <= 1'b0;
        end else if (m1_gnt_o && m1_lock_i) begin
            r_locked <= 1'b1;
        end else if (!m1_lock_i) begin
            r_locked <= 1'b0;
        end
    end

    // Release takes effect in the same cycle the lock input falls.
    assign w_lock_active = r_locked && m1_lock_i;
`else
    logic w_unused_lock;
    assign w_unused_lock = m1_lock_i;
    assign w_lock_active = 1'b0;
`endif

    assign w_full = (r_count == 3'(DEPTH));

    // Arbitration decision used while in the ARB state.
    always_comb begin
        w_arb_any = 1'b0;
        w_arb_sel = 1'b0;
        if (w_lock_active) begin
            w_arb_any = m1_req_i;
            w_arb_sel = 1'b1;
        end else if (m0_req_i && m1_req_i) begin
            w_arb_any = 1'b1;
            w_arb_sel = r_rr_prio;
        end else begin
            w_arb_any = m0_req_i || m1_req_i;
            w_arb_sel = m1_req_i;
        end
    end

    // FSM next state and downstream request selection.
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_sel        = 1'b0;
        if (!w_full) begin
            unique case (r_state)
                StArb: begin
                    w_req = w_arb_any;
                    w_sel = w_arb_sel;
                end
                StHold0: begin
                    w_req = m0_req_i;
                    w_sel = 1'b0;
                end
                StHold1: begin
                    w_req = m1_req_i;
                    w_sel = 1'b1;
                end
                default: begin
                    w_req = 1'b0;
                    w_sel = 1'b0;
                end
            endcase
        end
        unique case (r_state)
            StArb: begin
                if (w_req && !instr_gnt_i) begin
                    w_state_next = w_sel ? StHold1 : StHold0;
                end
            end
            // A dropped request in HOLD is a requester protocol violation; abandon it.
            StHold0: begin
                if (!m0_req_i || instr_gnt_i) begin
                    w_state_next = StArb;
                end
            end
            StHold1: begin
                if (!m1_req_i || instr_gnt_i) begin
                    w_state_next = StArb;
                end
            end
            default: w_state_next = StArb;
        endcase
    end

    assign instr_req_o  = w_req && !rst;
    assign instr_addr_o = instr_req_o ? (w_sel ? m1_addr_i : m0_addr_i) : 32'h0;
    assign w_push       = instr_req_o && instr_gnt_i;
    assign m0_gnt_o     = w_push && !w_sel;
    assign m1_gnt_o     = w_push && w_sel;

    assign w_head       = r_owner[r_rptr];
    assign w_pop        = instr_rvalid_i && (r_count != 3'd0) && !rst;
    assign m0_rvalid_o  = w_pop && !w_head;
    assign m1_rvalid_o  = w_pop && w_head;
    assign m0_err_o     = m0_rvalid_o && instr_err_i;
    assign m1_err_o     = m1_rvalid_o && instr_err_i;
    assign m0_rdata_o   = instr_rdata_i;
    assign m1_rdata_o   = instr_rdata_i;

    assign busy_o         = (r_count != 3'd0) || instr_req_o;
    assign protocol_err_o = r_protocol_err;

    // FSM state and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StArb;
            r_rr_prio <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_push) begin
                r_rr_prio <= ~w_sel;
            end
        end
    end

    // Owner FIFO, outstanding count and sticky spurious-response flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner        <= 4'h0;
            r_wptr         <= 2'd0;
            r_rptr         <= 2'd0;
            r_count        <= 3'd0;
            r_protocol_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_owner[r_wptr] <= w_sel;
                r_wptr          <= (r_wptr == 2'(DEPTH - 1)) ? 2'd0 : r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == 2'(DEPTH - 1)) ? 2'd0 : r_rptr + 2'd1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 3'd1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 3'd1;
            end
            if (instr_rvalid_i && (r_count == 3'd0)) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_instr_obi_arbiter.sv
// Scoreboard bench for cv32e40p_instr_obi_arbiter (DEPTH = 2).
// Expected lock behaviour follows CV32E40P_INSTR_ARB_LOCK_EN.
module tb_cv32e40p_instr_obi_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_i, m1_req_i, m1_lock_i;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_i;
    logic [31:0] instr_addr_o, instr_rdata_i;
    logic        busy_o, protocol_err_o;

    cv32e40p_instr_obi_arbiter #(.DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .m0_req_i       (m0_req_i),
        .m0_addr_i      (m0_addr_i),
        .m0_gnt_o       (m0_gnt_o),
        .m0_rvalid_o    (m0_rvalid_o),
        .m0_rdata_o     (m0_rdata_o),
        .m0_err_o       (m0_err_o),
        .m1_req_i       (m1_req_i),
        .m1_addr_i      (m1_addr_i),
        .m1_gnt_o       (m1_gnt_o),
        .m1_rvalid_o    (m1_rvalid_o),
        .m1_rdata_o     (m1_rdata_o),
        .m1_err_o       (m1_err_o),
        .m1_lock_i      (m1_lock_i),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .busy_o         (busy_o),
        .protocol_err_o (protocol_err_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        int unsigned cyc;
        logic        who;
        logic [31:0] data;
        logic        err;
    } ev_t;

    ev_t gnt_q[$];
    ev_t rsp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_cnt);
        end
    endtask

    task automatic exp_gnt(input logic who);
        ev_t e;
        e.cyc = cyc_cnt; e.who = who; e.data = 32'h0; e.err = 1'b0;
        gnt_q.push_back(e);
    endtask

    task automatic exp_rsp(input logic who, input logic [31:0] data, input logic err);
        ev_t e;
        e.cyc = cyc_cnt; e.who = who; e.data = data; e.err = err;
        rsp_q.push_back(e);
    endtask

    // Monitor: compares every grant/response the DUT presents against the queues.
    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            while (gnt_q.size() > 0 && gnt_q[0].cyc < cyc_cnt) begin
                e = gnt_q.pop_front();
                n_vec++; n_err++;
                $display("FAIL missed_grant: got none expected m%0d grant at cycle %0d",
                         e.who, e.cyc);
            end
            while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc_cnt) begin
                e = rsp_q.pop_front();
                n_vec++; n_err++;
                $display("FAIL missed_rvalid: got none expected m%0d rvalid at cycle %0d",
                         e.who, e.cyc);
            end
            if (m0_gnt_o || m1_gnt_o) begin
                if (gnt_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_grant: got gnt=%b%b expected none (cycle %0d)",
                             m1_gnt_o, m0_gnt_o, cyc_cnt);
                end else begin
                    e = gnt_q.pop_front();
                    chk("grant_owner", {30'h0, m1_gnt_o, m0_gnt_o}, e.who ? 32'd2 : 32'd1);
                end
            end
            if (m0_rvalid_o || m1_rvalid_o) begin
                if (rsp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_rvalid: got rvalid=%b%b expected none (cycle %0d)",
                             m1_rvalid_o, m0_rvalid_o, cyc_cnt);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rvalid_owner", {30'h0, m1_rvalid_o, m0_rvalid_o},
                        e.who ? 32'd2 : 32'd1);
                    chk("rdata", e.who ? m1_rdata_o : m0_rdata_o, e.data);
                    chk("err_owner", {30'h0, m1_err_o, m0_err_o},
                        e.err ? (e.who ? 32'd2 : 32'd1) : 32'd0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req_i = 0; m1_req_i = 0; m1_lock_i = 0;
        m0_addr_i = 32'h0; m1_addr_i = 32'h0;
        instr_gnt_i = 0; instr_rvalid_i = 0; instr_err_i = 0;
        instr_rdata_i = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle();
        instr_rdata_i = 32'hDEAD_BEEF;
        step();
        step();
        #1;
        chk("rst_req", {31'h0, instr_req_o}, 32'd0);
        chk("rst_gnt", {30'h0, m1_gnt_o, m0_gnt_o}, 32'd0);
        chk("rst_rvalid", {30'h0, m1_rvalid_o, m0_rvalid_o}, 32'd0);
        chk("rst_busy_perr", {30'h0, busy_o, protocol_err_o}, 32'd0);
        chk("rst_rdata_pass", m1_rdata_o, 32'hDEAD_BEEF);
        rst = 0;
        instr_rdata_i = 32'h0;
        step();
    endtask

    logic who;
    logic prev;

    initial begin
        rst = 1;
        idle();
        do_reset();

        // Single requester 0, immediate grant, response next cycle.
        m0_req_i = 1; m0_addr_i = 32'h0000_0080; instr_gnt_i = 1;
        exp_gnt(0);
        #1 chk("t1_addr", instr_addr_o, 32'h0000_0080);
        step();
        m0_req_i = 0; instr_gnt_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'h0000_0013;
        exp_rsp(0, 32'h0000_0013, 0);
        step();
        instr_rvalid_i = 0;

        // Both requesting with gnt always high: alternating grants and responses.
        do_reset();
        m0_req_i = 1; m0_addr_i = 32'h1000; m1_req_i = 1; m1_addr_i = 32'h2000;
        instr_gnt_i = 1;
        for (int k = 0; k < 4; k++) begin
            who = k[0];
            exp_gnt(who);
            if (k > 0) begin
                instr_rvalid_i = 1; instr_rdata_i = 32'h100 + k;
                exp_rsp(~who, 32'h100 + k, 0);
            end
            #1 chk("t2_addr", instr_addr_o, who ? 32'h2000 : 32'h1000);
            step();
        end
        m0_req_i = 0; m1_req_i = 0; instr_gnt_i = 0;
        instr_rvalid_i = 1; instr_rdata_i = 32'h104;
        exp_rsp(1, 32'h104, 0);
        step();
        instr_rvalid_i = 0;

        // Address phase held on m0 while gnt is low, even once m1 requests.
        do_reset();
        m0_req_i = 1; m0_addr_i = 32'h100;
        for (int k = 0; k < 3; k++) begin
            if (k >= 1) begin
                m1_req_i = 1; m1_addr_i = 32'h200;
            end
            #1 chk("t3_hold_addr", instr_addr_o, 32'h100);
            step();
        end
        instr_gnt_i = 1;
        exp_gnt(0);
        #1 chk("t3_gnt_addr", instr_addr_o, 32'h100);
        step();
        m0_req_i = 0;
        exp_gnt(1);
        #1 chk("t3_m1_addr", instr_addr_o, 32'h200);
        step();
        m1_req_i = 0; instr_gnt_i = 0;
        instr_rvalid_i = 1; instr_rdata_i = 32'h31; exp_rsp(0, 32'h31, 0);
        step();
        instr_rdata_i = 32'h32; exp_rsp(1, 32'h32, 0);
        step();
        instr_rvalid_i = 0;

        // FIFO full: no request, even with a same-cycle response; error routing.
        do_reset();
        m0_req_i = 1; m0_addr_i = 32'h400; instr_gnt_i = 1;
        exp_gnt(0);
        step();
        m0_req_i = 0; m1_req_i = 1; m1_addr_i = 32'h500;
        exp_gnt(1);
        step();
        m0_req_i = 1; m1_req_i = 0;
        #1 chk("t4_full_req", {31'h0, instr_req_o}, 32'd0);
        chk("t4_full_busy", {31'h0, busy_o}, 32'd1);
        step();
        instr_rvalid_i = 1; instr_rdata_i = 32'h41;
        exp_rsp(0, 32'h41, 0);
        #1 chk("t4_full_rv_req", {31'h0, instr_req_o}, 32'd0);
        step();
        instr_rvalid_i = 0;
        exp_gnt(0);
        #1 chk("t4_resume_req", {31'h0, instr_req_o}, 32'd1);
        step();
        m0_req_i = 0; instr_gnt_i = 0;
        instr_rvalid_i = 1; instr_rdata_i = 32'h42; instr_err_i = 1;
        exp_rsp(1, 32'h42, 1);
        step();
        instr_err_i = 0; instr_rdata_i = 32'h43;
        exp_rsp(0, 32'h43, 0);
        step();
        // Spurious response on an empty FIFO.
        instr_rdata_i = 32'h44;
        #1 chk("t5_perr_before", {31'h0, protocol_err_o}, 32'd0);
        step();
        instr_rvalid_i = 0;
        #1 chk("t5_perr_set", {31'h0, protocol_err_o}, 32'd1);
        step();
        step();
        chk("t5_perr_sticky", {31'h0, protocol_err_o}, 32'd1);
        chk("t5_idle_busy", {31'h0, busy_o}, 32'd0);

        // Reset with a transfer outstanding drops its ownership record.
        do_reset();
        m0_req_i = 1; m0_addr_i = 32'h800; instr_gnt_i = 1;
        exp_gnt(0);
        step();
        m0_req_i = 0; instr_gnt_i = 0;
        rst = 1;
        step();
        rst = 0;
        step();
        instr_rvalid_i = 1; instr_rdata_i = 32'h55;
        #1 chk("t5_discard_rv", {30'h0, m1_rvalid_o, m0_rvalid_o}, 32'd0);
        step();
        instr_rvalid_i = 0;
        #1 chk("t5_discard_perr", {31'h0, protocol_err_o}, 32'd1);

        // Requester 1 wins with lock asserted while m0 keeps requesting.
        do_reset();
        m1_req_i = 1; m1_lock_i = 1; m1_addr_i = 32'h600; instr_gnt_i = 1;
        exp_gnt(1);
        prev = 1;
        step();
        m0_req_i = 1; m0_addr_i = 32'h700;
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) m1_lock_i = 0;
`ifdef CV32E40P_INSTR_ARB_LOCK_EN
            who = (k == 5) ? 1'b0 : 1'b1;
`else
            who = ~k[0];
`endif
            exp_gnt(who);
            instr_rvalid_i = 1; instr_rdata_i = 32'h600 + k;
            exp_rsp(prev, 32'h600 + k, 0);
            prev = who;
            step();
        end
        m0_req_i = 0; m1_req_i = 0; instr_gnt_i = 0;
        instr_rdata_i = 32'h6FF;
        exp_rsp(prev, 32'h6FF, 0);
        step();
        instr_rvalid_i = 0;
        step();
        step();

        chk("grant_queue_drained", gnt_q.size(), 32'd0);
        chk("rsp_queue_drained", rsp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cv32e40p_instr_obi_arbiter.md
# cv32e40p_instr_obi_arbiter

Two-requester arbiter for the core's single instruction-memory OBI port. Requester 0 is the instruction prefetch path; requester 1 is an auxiliary fetcher, such as a debug program-buffer loader or an instruction-cache refill agent. The block selects one requester per transfer and keeps the downstream address phase stable until it is granted. It records the owner of every outstanding transfer in an in-order FIFO so that each `rvalid`, `rdata` and `err` response is routed back to the requester that issued it. It sits between the fetch units and the instruction bus, alongside the PMP.

## Interface
- `DEPTH`, 2: maximum number of outstanding granted-but-unanswered transfers. Range 1..4.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m0_req_i` / `m1_req_i`  in  1  requester address-phase request.
- `m0_addr_i` / `m1_addr_i`  in  32  requester fetch address, word aligned.
- `m0_gnt_o` / `m1_gnt_o`  out  1  address-phase grant to the requester.
- `m0_rvalid_o` / `m1_rvalid_o`  out  1  response valid to the requester.
- `m0_rdata_o` / `m1_rdata_o`  out  32  response data; both carry `instr_rdata_i` unconditionally.
- `m0_err_o` / `m1_err_o`  out  1  bus error; valid only together with the matching `rvalid`.
- `m1_lock_i`  in  1  requester 1 bus-lock request; functional only with the macro (see Configuration).
- `instr_req_o`  out  1  downstream OBI request.
- `instr_addr_o`  out  32  downstream address.
- `instr_gnt_i`  in  1  downstream grant.
- `instr_rvalid_i`  in  1  downstream response valid.
- `instr_rdata_i`  in  32  downstream response data.
- `instr_err_i`  in  1  downstream bus error.
- `busy_o`  out  1  high while any transfer is outstanding or `instr_req_o` is high.
- `protocol_err_o`  out  1  sticky flag: `rvalid` arrived with no outstanding transfer.

## Operation
**States:** ARB, HOLD0, HOLD1.

- **ARB**
  - Arbitrates only when the outstanding count is below `DEPTH`.
  - Only one requester active: that requester is selected.
  - Both active: the requester that did not win the last grant is selected (round-robin). The pointer resets to "requester 0 wins first".
  - The selection drives `instr_req_o` and `instr_addr_o`.
  - If `instr_gnt_i` is high, the grant is forwarded and the FSM stays in ARB.
  - If `instr_gnt_i` is low, the FSM moves to HOLDx for the selected requester x.
- **HOLDx**
  - The downstream mux is frozen on requester x, even if the other requester asserts.
  - This keeps the OBI address phase stable until granted.
  - On `instr_gnt_i`, the FSM returns to ARB and the round-robin pointer updates.
  - If requester x drops `req` (protocol violation), the FSM returns to ARB with no grant.
- **Granting a transfer**
  - The owner ID (1 bit) is pushed into the FIFO and the count increments.
  - Only one of `m0_gnt_o`/`m1_gnt_o` is ever high, and only when `instr_req_o && instr_gnt_i`.
- **FIFO full** (count == `DEPTH`)
  - `instr_req_o` is 0 and both grants are 0, even if `instr_rvalid_i` is high in the same cycle.
  - Arbitration resumes on the next cycle.
- **Response routing**
  - On `instr_rvalid_i`, the FIFO head is popped and the count decrements.
  - `rvalid` and `err` go to the head owner only.
  - A push and a pop in the same cycle leave the count unchanged.
- **Empty FIFO with `instr_rvalid_i`**
  - No requester `rvalid` is asserted.
  - `protocol_err_o` is set and stays set until reset.
- **Reset**
  - FSM goes to ARB; FIFO pointers and count go to 0; round-robin pointer selects requester 0; `protocol_err_o` goes to 0.
  - All outputs are 0, except `m0_rdata_o`/`m1_rdata_o`, which follow `instr_rdata_i`.
  - A reset while transfers are outstanding discards their ownership records.
  - Responses arriving after that reset count as spurious and set `protocol_err_o`.

## Timing
- The request path is combinational, requester to `instr_req_o`/`instr_addr_o`, with zero added latency in ARB.
- The grant path is combinational from `instr_gnt_i`.
- The response path is combinational from `instr_rvalid_i` and the registered FIFO head.
- FSM state, FIFO contents, count, round-robin pointer and `protocol_err_o` are registered.
- Back-to-back grants to alternating requesters are possible every cycle while count < `DEPTH`.
- No combinational path exists from `instr_rvalid_i` to `instr_req_o`.

## Configuration
- **`CV32E40P_INSTR_ARB_LOCK_EN` defined:**
  - When requester 1 wins a grant with `m1_lock_i` high, the arbiter enters a locked condition.
  - While locked, requester 0 is never selected.
  - The lock releases in the first cycle in which `m1_lock_i` is low.
- **Macro undefined:**
  - `m1_lock_i` is ignored and no lock state is implemented.
  - Arbitration is pure round-robin.

## Test plan
- Single requester 0, gnt always 1, rvalid one cycle after grant, addr 0x0000_0080 → `m0_gnt_o` in the same cycle, `m0_rvalid_o` one cycle later with rdata 0x0000_0013, `m1_*` quiet.
- Both requesting, gnt always 1 → grants alternate m0, m1, m0, m1 on consecutive cycles. Responses in order route rvalid to m0, m1, m0, m1.
- `instr_gnt_i` held low for 3 cycles with m0 requesting 0x100, then m1 asserting 0x200 → `instr_addr_o` stays 0x100 for all 3 cycles. The first grant goes to m0; m1 is granted next.
- `DEPTH`=2, two grants with no responses → `instr_req_o`=0 while full. Full with rvalid in the same cycle → still no grant that cycle; a grant follows the next cycle.
- rvalid with `instr_err_i`=1 for an m1-owned transfer → `m1_err_o`=1 and `m0_rvalid_o`=0. rvalid with an empty FIFO → `protocol_err_o`=1 and it remains set.
- Lock build: m1 wins with lock=1 and m0 is requesting → m0 is not granted for 4 cycles. Lock drops → m0 is granted next. In a non-lock build, the same stimulus alternates grants.
